// File: rtl/branch_pkg.sv
// branch_pkg: branch type encodings and queue entry field layout
package branch_pkg;
  typedef enum logic [1:0] {
    TYPE_NONE = 2'd0,
    TYPE_COND = 2'd1,
    TYPE_CALL = 2'd2,
    TYPE_RET  = 2'd3
  } br_type_e;
  localparam int REASON_OFF = 0;
  localparam int BRANCH_OFF = 1;
  localparam int PDPC_OFF   = 2;
  function automatic int pc_off(int aw);
    return PDPC_OFF + aw;
  endfunction
  function automatic int entry_width(int aw);
    return 2 * aw + 2;
  endfunction
endpackage

// File: rtl/bq_fifo.sv
// bq_fifo: DEPTH x WIDTH register FIFO with clear and push-through-pop when full
module bq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rp];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order prediction queue resolved at EX, drives predictor training and redirect
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ifPush,
  input  logic [ADDR_WIDTH-1:0] ifPC,
  input  logic [ADDR_WIDTH-1:0] ifPdPC,
  input  logic                  ifPdBranch,
  input  logic                  ifPdReason,
  output logic                  qFull,
  output logic                  qEmpty,
  output logic [PTR_WIDTH:0]    qCount,
  input  logic                  exDone,
  input  logic [ADDR_WIDTH-1:0] exPC,
  input  logic [ADDR_WIDTH-1:0] exNextPC,
  input  logic [ADDR_WIDTH-1:0] exPCTar,
  input  logic [1:0]            exType,
  input  logic                  exBranch,
  input  logic                  flush,
  output logic                  upVld,
  output logic [ADDR_WIDTH-1:0] upPC,
  output logic [ADDR_WIDTH-1:0] upPCTar,
  output logic [1:0]            upType,
  output logic                  upBranch,
  output logic                  upWrong,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirectPC,
  output logic [CNT_WIDTH-1:0]  mispCnt,
  output logic                  errPopEmpty
);
  localparam int EW = entry_width(ADDR_WIDTH);
  localparam int PO = pc_off(ADDR_WIDTH);
  logic [EW-1:0] din, head;
  logic [ADDR_WIDTH-1:0] head_pd;
  logic pop, wrong, misp, unused_head;
  assign din     = {ifPC, ifPdPC, ifPdBranch, ifPdReason};
  assign head_pd = head[PDPC_OFF +: ADDR_WIDTH];
  assign pop     = exDone && !qEmpty;
  assign wrong   = head_pd != exNextPC;
  assign misp    = pop && wrong;
  assign unused_head = ^{head[PO +: ADDR_WIDTH], head[BRANCH_OFF], head[REASON_OFF]};
  // a mispredict clears the queue, which also drops any wrong-path push this cycle
  bq_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .PW(PTR_WIDTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ifPush),
    .pop   (pop),
    .clear (flush || misp),
    .din   (din),
    .full  (qFull),
    .empty (qEmpty),
    .count (qCount),
    .head  (head)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      upVld       <= 1'b0;
      upPC        <= '0;
      upPCTar     <= '0;
      upType      <= '0;
      upBranch    <= 1'b0;
      upWrong     <= 1'b0;
      redirect    <= 1'b0;
      redirectPC  <= '0;
      mispCnt     <= '0;
      errPopEmpty <= 1'b0;
    end else begin
      upVld       <= pop;
      upPC        <= pop ? exPC : '0;
      upPCTar     <= pop ? exPCTar : '0;
      upType      <= pop ? exType : '0;
      upBranch    <= pop && exBranch;
      upWrong     <= misp;
      redirect    <= misp && !flush;
      redirectPC  <= pop ? exNextPC : redirectPC;
      mispCnt     <= mispCnt + CNT_WIDTH'(misp && mispCnt != '1);
      errPopEmpty <= errPopEmpty || (exDone && qEmpty);
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed plus random stimulus against a queue-based reference model
module tb_branch_resolve_queue;
  localparam int AW = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;
  logic clk = 0, rstn = 0;
  logic ifPush = 0, ifPdBranch = 0, ifPdReason = 0;
  logic [AW-1:0] ifPC = 0, ifPdPC = 0, exPC = 0, exNextPC = 0, exPCTar = 0;
  logic exDone = 0, exBranch = 0, flush = 0;
  logic [1:0] exType = 0;
  logic qFull, qEmpty, upVld, upBranch, upWrong, redirect, errPopEmpty;
  logic [3:0] qCount;
  logic [AW-1:0] upPC, upPCTar, redirectPC;
  logic [1:0] upType;
  logic [CW-1:0] mispCnt;
  branch_resolve_queue #(.ADDR_WIDTH(AW), .DEPTH(8), .PTR_WIDTH(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .ifPush(ifPush), .ifPC(ifPC), .ifPdPC(ifPdPC),
    .ifPdBranch(ifPdBranch), .ifPdReason(ifPdReason), .qFull(qFull), .qEmpty(qEmpty),
    .qCount(qCount), .exDone(exDone), .exPC(exPC), .exNextPC(exNextPC), .exPCTar(exPCTar),
    .exType(exType), .exBranch(exBranch), .flush(flush), .upVld(upVld), .upPC(upPC),
    .upPCTar(upPCTar), .upType(upType), .upBranch(upBranch), .upWrong(upWrong),
    .redirect(redirect), .redirectPC(redirectPC), .mispCnt(mispCnt), .errPopEmpty(errPopEmpty)
  );
  always #5 clk = ~clk;
  logic [AW-1:0] q[$];
  logic e_vld, e_branch, e_wrong, e_redir, e_err;
  logic [AW-1:0] e_pc, e_tar, e_rpc;
  logic [1:0] e_type;
  logic [CW-1:0] e_cnt;
  int passed = 0, total = 0;
  task automatic check(string tag, logic [AW-1:0] got, logic [AW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    bit pop, wr;
    if (!rstn) begin
      q.delete();
      {e_vld, e_branch, e_wrong, e_redir, e_err} = '0;
      {e_pc, e_tar, e_rpc, e_type, e_cnt} = '0;
    end else begin
      pop = exDone && q.size() > 0;
      wr  = pop && q[0] != exNextPC;
      e_vld = pop;
      e_pc = pop ? exPC : 0;
      e_tar = pop ? exPCTar : 0;
      e_type = pop ? exType : 0;
      e_branch = pop && exBranch;
      e_wrong = wr;
      e_redir = wr && !flush;
      if (pop) e_rpc = exNextPC;
      if (exDone && q.size() == 0) e_err = 1;
      if (wr && e_cnt != CMAX) e_cnt++;
      if (flush || wr) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (ifPush && q.size() < 8) q.push_back(ifPdPC);
      end
    end
    @(posedge clk);
    #1;
    check("upVld", AW'(upVld), AW'(e_vld));
    check("upPC", upPC, e_pc);
    check("upPCTar", upPCTar, e_tar);
    check("upType", AW'(upType), AW'(e_type));
    check("upBranch", AW'(upBranch), AW'(e_branch));
    check("upWrong", AW'(upWrong), AW'(e_wrong));
    check("redirect", AW'(redirect), AW'(e_redir));
    check("redirectPC", redirectPC, e_rpc);
    check("mispCnt", AW'(mispCnt), AW'(e_cnt));
    check("errPopEmpty", AW'(errPopEmpty), AW'(e_err));
    check("qCount", AW'(qCount), AW'(q.size()));
    check("qEmpty", AW'(qEmpty), AW'(q.size() == 0));
    check("qFull", AW'(qFull), AW'(q.size() == 8));
    {ifPush, exDone, flush, exBranch} = '0;
  endtask
  task automatic push_in(logic [AW-1:0] pc);
    ifPush = 1;
    ifPC = pc;
    ifPdPC = pc + 8;
    ifPdBranch = pc[3];
    ifPdReason = pc[4];
  endtask
  task automatic resolve(logic [AW-1:0] pc, logic [AW-1:0] nxt, logic br);
    exDone = 1;
    exPC = pc;
    exNextPC = nxt;
    exPCTar = pc + 32'h40;
    exType = br ? 2'd1 : 2'd0;
    exBranch = br;
  endtask
  initial begin
    rstn = 0;
    tick();
    rstn = 1;
    for (int i = 0; i < 9; i++) begin
      push_in(32'h1c000000 + 8 * i);
      tick();
    end
    resolve(32'h1c000000, 32'h1c000008, 0);
    tick();
    resolve(32'h1c000008, 32'h1c000100, 1);
    push_in(32'h1c000200);
    tick();
    for (int i = 0; i < 8; i++) begin
      push_in(32'h1c001000 + 8 * i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      push_in(32'h1c002000 + 8 * i);
      resolve(32'h1c003000 + i, q[0], i[0]);
      tick();
    end
    resolve(32'h1c004000, 32'h1c00dead, 1);
    flush = 1;
    tick();
    tick();
    resolve(32'h1c005000, 32'h1c005008, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      push_in(32'h1c006000 + 8 * i);
      tick();
      resolve(32'h1c006000 + 8 * i, 32'h1c00beef, 1);
      tick();
    end
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) rstn = 0;
      else rstn = 1;
      if ($urandom_range(3) != 0) push_in($urandom & 32'hfffffff8);
      if ($urandom_range(2) == 0) begin
        resolve($urandom, $urandom, $urandom_range(1));
        exPCTar = $urandom;
        exType = 2'($urandom);
        if (q.size() > 0 && $urandom_range(3) != 0) exNextPC = q[0];
      end
      flush = $urandom_range(30) == 0;
      tick();
    end
    rstn = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
